// File: rtl/cdb_arbiter_if.sv
// Result-source and common-data-bus signal bundle for the CDB arbiter.
// The arbiter takes the slave view; functional units and consumers take the master view.
interface cdb_arbiter_if #(
    parameter int N_SRC = 3,
    parameter int DW    = 16,
    parameter int TAGW  = 3
);
    logic                  flush;
    logic [N_SRC-1:0]      src_valid;
    logic [N_SRC-1:0]      src_ready;
    logic [N_SRC*DW-1:0]   src_data;
    logic [N_SRC*3-1:0]    src_dest;
    logic [N_SRC*TAGW-1:0] src_tag;
    logic                  cdb_valid;
    logic [TAGW-1:0]       cdb_tag;
    logic [DW-1:0]         cdb_data;
    logic [2:0]            cdb_dest;
    logic                  rf_we;
    logic [2:0]            rf_addr;
    logic [DW-1:0]         rf_data;
    logic                  busy;

    modport master (
        output flush, src_valid, src_data, src_dest, src_tag,
        input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_dest,
        input  rf_we, rf_addr, rf_data, busy
    );

    modport slave (
        input  flush, src_valid, src_data, src_dest, src_tag,
        output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_dest,
        output rf_we, rf_addr, rf_data, busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source result FIFOs, round-robin grant, registered
// CDB broadcast, and the FP register-file write port for destinations R1-R7.
module cdb_arbiter #(
    parameter int N_SRC = 3,
    parameter int DW    = 16,
    parameter int TAGW  = 3,
    parameter int DEPTH = 2
) (
    input logic         clock,
    input logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [2:0]      dest;
        logic [TAGW-1:0] tag;
    } resultT;

    resultT          mem   [N_SRC][DEPTH];
    logic [PW-1:0]   rdPtr [N_SRC];
    logic [PW-1:0]   wrPtr [N_SRC];
    logic [CW-1:0]   count [N_SRC];

    logic [N_SRC-1:0] notEmpty;
    logic [N_SRC-1:0] notFull;
    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] pop;
    logic [IW-1:0]    rrPtr;
    logic [IW-1:0]    candIdx;
    logic [IW-1:0]    grantIdx;
    logic [IW-1:0]    nextRr;
    logic             grantValid;
    resultT           head;
    resultT           cdbReg;
    logic             cdbValid;

    // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
    always_comb begin
        notEmpty = '0;
        notFull  = '0;
        push     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            notEmpty[i] = (count[i] != '0);
            notFull[i]  = (count[i] != CW'(DEPTH));
            push[i]     = bus.src_valid[i] && notFull[i] && !bus.flush;
        end
    end

    // Round-robin search starting at rrPtr; only registered occupancy is eligible, so no bypass.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            candIdx = IW'((int'(rrPtr) + k) % N_SRC);
            if (!grantValid && notEmpty[candIdx]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx;
            end
        end
        nextRr = (grantIdx == IW'(N_SRC - 1)) ? '0 : grantIdx + 1'b1;
        pop    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pop[i] = grantValid && (grantIdx == IW'(i));
        end
        head = mem[grantIdx][rdPtr[grantIdx]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                rdPtr[i] <= '0;
                wrPtr[i] <= '0;
                count[i] <= '0;
            end
            rrPtr    <= '0;
            cdbValid <= 1'b0;
            cdbReg   <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                rdPtr[i] <= '0;
                wrPtr[i] <= '0;
                count[i] <= '0;
            end
            cdbValid <= 1'b0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) wrPtr[i] <= wrPtr[i] + 1'b1;
                if (pop[i])  rdPtr[i] <= rdPtr[i] + 1'b1;
                if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
                else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
            end
            cdbValid <= grantValid;
            if (grantValid) begin
                cdbReg <= head;
                rrPtr  <= nextRr;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the occupancy counters alone decide which entries are live.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                mem[i][wrPtr[i]] <= '{data: bus.src_data[i*DW +: DW],
                                      dest: bus.src_dest[i*3 +: 3],
                                      tag:  bus.src_tag[i*TAGW +: TAGW]};
            end
        end
    end

    assign bus.src_ready = notFull;
    assign bus.cdb_valid = cdbValid;
    assign bus.cdb_tag   = cdbReg.tag;
    assign bus.cdb_data  = cdbReg.data;
    assign bus.cdb_dest  = cdbReg.dest;
    assign bus.rf_we     = cdbValid && (cdbReg.dest != 3'd0);
    assign bus.rf_addr   = cdbReg.dest;
    assign bus.rf_data   = cdbReg.data;
    assign bus.busy      = (|notEmpty) || cdbValid;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-source scoreboard that checks every
// broadcast for order, loss, duplication, register-file write and starvation.
module tb_cdb_arbiter;
    localparam int N_SRC = 3;
    localparam int DW    = 16;
    localparam int TAGW  = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [2:0]  tag;
        logic [15:0] data;
        logic [2:0]  dest;
    } resultT;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cdb_arbiter_if #(.N_SRC(N_SRC), .DW(DW), .TAGW(TAGW)) bus ();

    cdb_arbiter #(.N_SRC(N_SRC), .DW(DW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    resultT sb [N_SRC][$];
    int waitCnt [N_SRC];
    int maxWait = 0;
    int hit;
    logic [N_SRC-1:0] hadEntry;
    resultT obs;
    resultT exp;

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input logic [15:0] d, input logic [2:0] dst, input logic [2:0] t);
        bus.src_valid[i]               = 1'b1;
        bus.src_data[i*DW +: DW]       = d;
        bus.src_dest[i*3 +: 3]         = dst;
        bus.src_tag[i*TAGW +: TAGW]    = t;
    endtask

    task automatic idle(input int i);
        bus.src_valid[i] = 1'b0;
    endtask

    // Scoreboard: record accepted pushes before each edge, match broadcasts against per-source heads.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                sb[i].delete();
                waitCnt[i] = 0;
            end
        end else begin
            hit = -1;
            for (int i = 0; i < N_SRC; i++) hadEntry[i] = (sb[i].size() > 0);
            if (bus.cdb_valid) begin
                obs = '{tag: bus.cdb_tag, data: bus.cdb_data, dest: bus.cdb_dest};
                for (int i = 0; i < N_SRC; i++)
                    if (hit < 0 && sb[i].size() > 0 && sb[i][0] == obs) hit = i;
                check("cdbExpected", 32'(hit >= 0), 32'd1);
                if (hit >= 0) begin
                    exp = sb[hit].pop_front();
                    check("rfWe", 32'(bus.rf_we), 32'(exp.dest != 3'd0));
                    check("rfAddr", 32'(bus.rf_addr), 32'(exp.dest));
                    check("rfData", 32'(bus.rf_data), 32'(exp.data));
                end
            end else begin
                check("rfWeIdle", 32'(bus.rf_we), 32'd0);
            end
            for (int i = 0; i < N_SRC; i++) begin
                if (hadEntry[i] && hit != i) waitCnt[i]++;
                else waitCnt[i] = 0;
                if (waitCnt[i] > maxWait) maxWait = waitCnt[i];
            end
            if (bus.flush) begin
                for (int i = 0; i < N_SRC; i++) begin
                    sb[i].delete();
                    waitCnt[i] = 0;
                end
            end else begin
                for (int i = 0; i < N_SRC; i++)
                    if (bus.src_valid[i] && bus.src_ready[i])
                        sb[i].push_back('{tag:  bus.src_tag[i*TAGW +: TAGW],
                                          data: bus.src_data[i*DW +: DW],
                                          dest: bus.src_dest[i*3 +: 3]});
            end
        end
    end

    int n0 = 0;
    int n1 = 0;
    logic [N_SRC-1:0] rdy;
    logic [15:0] rrData [6];

    task automatic bp();
        drive(0, 16'hB000 + 16'(n0), 3'(n0), 3'(n0));
        drive(1, 16'hC000 + 16'(n1), 3'd2, 3'(n1 + 4));
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.src_dest  = '0;
        bus.src_tag   = '0;
        rrData = '{16'hA001, 16'hA002, 16'hA003, 16'hB001, 16'hB002, 16'hB003};

        // Reset state
        step();
        step();
        check("rstReady",   32'(bus.src_ready), 32'h7);
        check("rstValid",   32'(bus.cdb_valid), 32'd0);
        check("rstTag",     32'(bus.cdb_tag),   32'd0);
        check("rstData",    32'(bus.cdb_data),  32'd0);
        check("rstDest",    32'(bus.cdb_dest),  32'd0);
        check("rstRfWe",    32'(bus.rf_we),     32'd0);
        check("rstRfAddr",  32'(bus.rf_addr),   32'd0);
        check("rstRfData",  32'(bus.rf_data),   32'd0);
        check("rstBusy",    32'(bus.busy),      32'd0);
        reset = 1'b0;

        // Single result from source 0
        drive(0, 16'h0042, 3'd3, 3'd1);
        step();
        idle(0);
        check("noBypass",   32'(bus.cdb_valid), 32'd0);
        check("busyQueued", 32'(bus.busy),      32'd1);
        step();
        check("oneValid",   32'(bus.cdb_valid), 32'd1);
        check("oneData",    32'(bus.cdb_data),  32'h0042);
        check("oneTag",     32'(bus.cdb_tag),   32'd1);
        check("oneRfWe",    32'(bus.rf_we),     32'd1);
        check("oneRfAddr",  32'(bus.rf_addr),   32'd3);
        step();
        check("oneDoneValid", 32'(bus.cdb_valid), 32'd0);
        check("oneDoneBusy",  32'(bus.busy),      32'd0);

        // R0 is broadcast but never written
        drive(1, 16'h1234, 3'd0, 3'd5);
        step();
        idle(1);
        check("r0RfWePre",  32'(bus.rf_we), 32'd0);
        step();
        check("r0Valid",    32'(bus.cdb_valid), 32'd1);
        check("r0Dest",     32'(bus.cdb_dest),  32'd0);
        check("r0Data",     32'(bus.cdb_data),  32'h1234);
        check("r0RfWe",     32'(bus.rf_we),     32'd0);
        step();
        check("r0RfWePost", 32'(bus.rf_we),     32'd0);

        // Flush with source 0 holding two entries (rr points at source 2 here)
        drive(0, 16'h5001, 3'd1, 3'd2);
        drive(2, 16'h5002, 3'd2, 3'd4);
        step();
        drive(0, 16'h5003, 3'd3, 3'd6);
        idle(2);
        step();
        idle(0);
        check("flushFullReady", 32'(bus.src_ready), 32'h6);
        check("flushPreTag",    32'(bus.cdb_tag),   32'd4);
        bus.flush = 1'b1;
        drive(1, 16'h5004, 3'd4, 3'd7);
        step();
        bus.flush = 1'b0;
        idle(1);
        check("flushValid", 32'(bus.cdb_valid), 32'd0);
        check("flushReady", 32'(bus.src_ready), 32'h7);
        check("flushBusy",  32'(bus.busy),      32'd0);
        drive(1, 16'h5005, 3'd5, 3'd3);
        step();
        idle(1);
        step();
        check("postFlushValid", 32'(bus.cdb_valid), 32'd1);
        check("postFlushData",  32'(bus.cdb_data),  32'h5005);
        step();
        check("postFlushBusy",  32'(bus.busy),      32'd0);

        // Source 2 alone, destination R7; leaves rr at 0
        drive(2, 16'h0777, 3'd7, 3'd6);
        step();
        idle(2);
        step();
        check("src2Valid",  32'(bus.cdb_valid), 32'd1);
        check("src2RfAddr", 32'(bus.rf_addr),   32'd7);
        check("src2RfWe",   32'(bus.rf_we),     32'd1);
        step();

        // Round-robin contention, two back-to-back rounds
        drive(0, 16'hA001, 3'd1, 3'd1);
        drive(1, 16'hA002, 3'd2, 3'd2);
        drive(2, 16'hA003, 3'd4, 3'd3);
        step();
        drive(0, 16'hB001, 3'd1, 3'd1);
        drive(1, 16'hB002, 3'd2, 3'd2);
        drive(2, 16'hB003, 3'd4, 3'd3);
        step();
        for (int i = 0; i < N_SRC; i++) idle(i);
        check("rrReady", 32'(bus.src_ready), 32'h1);
        for (int n = 0; n < 6; n++) begin
            check("rrTag",  32'(bus.cdb_tag),  32'(n % 3 + 1));
            check("rrData", 32'(bus.cdb_data), 32'(rrData[n]));
            step();
        end
        check("rrDoneValid", 32'(bus.cdb_valid), 32'd0);
        check("rrDoneBusy",  32'(bus.busy),      32'd0);

        // Backpressure: source 1 held valid against continuous source-0 traffic
        bp();
        step();
        n0++;
        n1++;
        check("bpReadyFirst", 32'(bus.src_ready), 32'h7);
        bp();
        step();
        n0++;
        n1++;
        check("bpFull1",  32'(bus.src_ready[1]), 32'd0);
        check("bpReady0", 32'(bus.src_ready[0]), 32'd1);
        for (int c = 0; c < 12; c++) begin
            rdy = bus.src_ready;
            bp();
            step();
            if (rdy[0]) n0++;
            if (rdy[1]) n1++;
        end
        idle(0);
        idle(1);
        for (int c = 0; c < 8; c++) step();
        check("bpDrained", 32'(bus.busy), 32'd0);

        // Async reset mid-stream, then rr restarts at source 0
        drive(1, 16'hD001, 3'd5, 3'd1);
        step();
        drive(1, 16'hD002, 3'd6, 3'd2);
        step();
        idle(1);
        check("preRstValid", 32'(bus.cdb_valid), 32'd1);
        check("preRstRfWe",  32'(bus.rf_we),     32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("asyncValid", 32'(bus.cdb_valid), 32'd0);
        check("asyncRfWe",  32'(bus.rf_we),     32'd0);
        check("asyncBusy",  32'(bus.busy),      32'd0);
        check("asyncReady", 32'(bus.src_ready), 32'h7);
        step();
        reset = 1'b0;
        drive(0, 16'hE000, 3'd1, 3'd5);
        drive(2, 16'hE002, 3'd2, 3'd6);
        step();
        idle(0);
        idle(2);
        step();
        check("rstRrFirst",  32'(bus.cdb_tag), 32'd5);
        step();
        check("rstRrSecond", 32'(bus.cdb_tag), 32'd6);
        step();
        check("finalBusy",   32'(bus.busy),    32'd0);

        step();
        check("starvation", 32'(maxWait <= N_SRC), 32'd1);
        for (int i = 0; i < N_SRC; i++) check("sbEmpty", 32'(sb[i].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
